// File: rtl/mem_xfer_fsm.sv
// ============================================================================
// Module  : mem_xfer_fsm
// Brief   : LOAD/STORE memory-transfer controller (MAR/MDR + MFC handshake)
//           with WAIT timeout. Optional macro XFER_AUTOINC_EN adds Ri post-inc.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_xfer_fsm #(
    parameter int NUM_REGS = 5,
    parameter int SEL_W    = 6,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                op,
    input  logic [SEL_W-1:0]    Ri,
    input  logic [SEL_W-1:0]    Rj,
`ifdef XFER_AUTOINC_EN
    input  logic                autoinc,
    output logic [NUM_REGS-1:0] reg_inc,
`endif
    input  logic                MFC,
    output logic [NUM_REGS-1:0] reg_read,
    output logic [NUM_REGS-1:0] reg_write,
    output logic                MAR_write,
    output logic                MAR_mem_read,
    output logic                MEM_EN,
    output logic                MEM_RW,
    output logic                MDR_mem_write,
    output logic                MDR_read,
    output logic                MDR_write,
    output logic                MDR_mem_read,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ADDR = 4'd1,
        S_DATA = 4'd2,
        S_REQ  = 4'd3,
        S_WAIT = 4'd4,
        S_CAPT = 4'd5,
        S_WB   = 4'd6,
        S_DONE = 4'd7,
        S_ERR  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [SEL_W-1:0]    ri_q, ri_d;
    logic [SEL_W-1:0]    rj_q, rj_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] ri_oh, rj_oh;
    logic                bad_idx;
    logic                wait_expired;
`ifdef XFER_AUTOINC_EN
    logic                ainc_q, ainc_d;
`endif

    // One-hot decode of the latched selectors; out-of-range indices decode to zero.
    always_comb begin
        ri_oh = '0;
        rj_oh = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            ri_oh[k] = (int'(ri_q) == k);
            rj_oh[k] = (int'(rj_q) == k);
        end
    end

    assign bad_idx      = (int'(Ri) >= NUM_REGS) || (int'(Rj) >= NUM_REGS);
    assign wait_expired = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            ri_q    <= '0;
            rj_q    <= '0;
            cnt_q   <= '0;
`ifdef XFER_AUTOINC_EN
            ainc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ri_q    <= ri_d;
            rj_q    <= rj_d;
            cnt_q   <= cnt_d;
`ifdef XFER_AUTOINC_EN
            ainc_q  <= ainc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ri_d    = ri_q;
        rj_d    = rj_q;
        cnt_d   = cnt_q;
`ifdef XFER_AUTOINC_EN
        ainc_d  = ainc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    ri_d    = Ri;
                    rj_d    = Rj;
`ifdef XFER_AUTOINC_EN
                    ainc_d  = autoinc;
`endif
                    state_d = bad_idx ? S_ERR : S_ADDR;
                end
            end
            S_ADDR:  state_d = op_q ? S_DATA : S_REQ;
            S_DATA:  state_d = S_REQ;
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // MFC takes priority over a timeout landing on the same cycle.
                if (MFC) begin
                    state_d = op_q ? S_DONE : S_CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (wait_expired) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_CAPT:  state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_read      = '0;
        reg_write     = '0;
        MAR_write     = 1'b0;
        MAR_mem_read  = 1'b0;
        MEM_EN        = 1'b0;
        MEM_RW        = 1'b0;
        MDR_mem_write = 1'b0;
        MDR_read      = 1'b0;
        MDR_write     = 1'b0;
        MDR_mem_read  = 1'b0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        err           = 1'b0;
`ifdef XFER_AUTOINC_EN
        reg_inc       = '0;
`endif
        case (state_q)
            S_ADDR: begin
                reg_read  = ri_oh;
                MAR_write = 1'b1;
            end
            S_DATA: begin
                reg_read  = rj_oh;
                MDR_write = 1'b1;
            end
            S_REQ, S_WAIT: begin
                MEM_EN       = 1'b1;
                MAR_mem_read = 1'b1;
                MEM_RW       = ~op_q;
                MDR_mem_read = op_q;
            end
            S_CAPT:  MDR_mem_write = 1'b1;
            S_WB: begin
                MDR_read  = 1'b1;
                reg_write = rj_oh;
            end
            S_DONE: begin
                done = 1'b1;
`ifdef XFER_AUTOINC_EN
                reg_inc = ainc_q ? ri_oh : '0;
`endif
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_fsm.sv
// ============================================================================
// Module  : tb_mem_xfer_fsm
// Brief   : Self-checking bench for mem_xfer_fsm: per-cycle trace model plus
//           directed latency/strobe checks and randomized transfers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_xfer_fsm;

    localparam int N  = 5;
    localparam int SW = 6;
    localparam int WM = 15;
    localparam int CW = 8;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic [N-1:0] rr;
        logic [N-1:0] rw;
        logic [N-1:0] inc;
        logic marw, marmr, memen, memrw, mdrmw, mdrr, mdrw, mdrmr, busy, done, err;
    } outs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic          MFC = 1'b0;
    logic [SW-1:0] Ri = '0;
    logic [SW-1:0] Rj = '0;
    logic [N-1:0]  reg_read, reg_write;
    logic          MAR_write, MAR_mem_read, MEM_EN, MEM_RW, MDR_mem_write;
    logic          MDR_read, MDR_write, MDR_mem_read, busy, done, err;
`ifdef XFER_AUTOINC_EN
    logic          autoinc = 1'b0;
    logic [N-1:0]  reg_inc;
`endif

    mem_xfer_fsm #(.NUM_REGS(N), .SEL_W(SW), .WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .Ri(Ri), .Rj(Rj),
`ifdef XFER_AUTOINC_EN
        .autoinc(autoinc), .reg_inc(reg_inc),
`endif
        .MFC(MFC), .reg_read(reg_read), .reg_write(reg_write),
        .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read), .MEM_EN(MEM_EN),
        .MEM_RW(MEM_RW), .MDR_mem_write(MDR_mem_write), .MDR_read(MDR_read),
        .MDR_write(MDR_write), .MDR_mem_read(MDR_mem_read), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    start_cyc = 0;
    bit    chk_en  = 1'b0;
    outs_t exp_o   = '0;
    outs_t trace[$];
    int    widx[$];

    int mon_addr_rr, mon_data_rr, mon_wb, mon_inc, mon_memen, mon_marw, mon_rw1;
    int mon_done_lat, mon_done_n, mon_err_lat, mon_err_n;

    always @(posedge clk) cyc++;

    function automatic outs_t dut_outs();
        outs_t o = '0;
        o.rr = reg_read;  o.rw = reg_write;
        o.marw = MAR_write; o.marmr = MAR_mem_read; o.memen = MEM_EN; o.memrw = MEM_RW;
        o.mdrmw = MDR_mem_write; o.mdrr = MDR_read; o.mdrw = MDR_write;
        o.mdrmr = MDR_mem_read; o.busy = busy; o.done = done; o.err = err;
`ifdef XFER_AUTOINC_EN
        o.inc = reg_inc;
`endif
        return o;
    endfunction

    function automatic logic [N-1:0] oh(int x);
        return (x >= 0 && x < N) ? (N'(1) << x) : '0;
    endfunction

    // Per-cycle comparison against the model trace.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (dut_outs() !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_outputs cyc=%0d got=%h want=%h", cyc, dut_outs(), exp_o);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (MAR_write)   mon_addr_rr = int'(reg_read);
            if (MDR_write)   mon_data_rr = int'(reg_read);
            if (|reg_write)  mon_wb      = int'(reg_write);
            if (MEM_EN)      mon_memen++;
            if (MAR_write)   mon_marw++;
            if (MEM_EN && MEM_RW) mon_rw1++;
            if (done) begin mon_done_lat = cyc - start_cyc; mon_done_n++; end
            if (err)  begin mon_err_lat  = cyc - start_cyc; mon_err_n++;  end
`ifdef XFER_AUTOINC_EN
            if (|reg_inc) mon_inc = int'(reg_inc);
`endif
        end
    end

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Expected output sequence for one launch, one entry per cycle after start.
    // d = number of WAIT cycles with MFC low before it rises (NEVER = no MFC).
    task automatic build_trace(input bit o, input int ri, input int rj, input int d, input bit ai);
        outs_t e;
        bit    tout;
        int    nwait;
        trace.delete();
        widx.delete();
        if (ri >= N || rj >= N) begin
            e = '0; e.busy = 1; e.err = 1;
            trace.push_back(e); widx.push_back(-1);
            return;
        end
        e = '0; e.busy = 1; e.rr = oh(ri); e.marw = 1;
        trace.push_back(e); widx.push_back(-1);
        if (o) begin
            e = '0; e.busy = 1; e.rr = oh(rj); e.mdrw = 1;
            trace.push_back(e); widx.push_back(-1);
        end
        e = '0; e.busy = 1; e.memen = 1; e.marmr = 1; e.memrw = ~o; e.mdrmr = o;
        trace.push_back(e); widx.push_back(-1);
        tout  = (WM != 0) && (d >= WM);
        nwait = tout ? WM : d + 1;
        for (int k = 0; k < nwait; k++) begin
            trace.push_back(e); widx.push_back(k);
        end
        if (tout) begin
            e = '0; e.busy = 1; e.err = 1;
            trace.push_back(e); widx.push_back(-1);
            return;
        end
        if (!o) begin
            e = '0; e.busy = 1; e.mdrmw = 1;
            trace.push_back(e); widx.push_back(-1);
            e = '0; e.busy = 1; e.mdrr = 1; e.rw = oh(rj);
            trace.push_back(e); widx.push_back(-1);
        end
        e = '0; e.busy = 1; e.done = 1; e.inc = ai ? oh(ri) : '0;
        trace.push_back(e); widx.push_back(-1);
    endtask

    task automatic clear_mon();
        mon_addr_rr = 0; mon_data_rr = 0; mon_wb = 0; mon_inc = 0; mon_memen = 0;
        mon_marw = 0; mon_rw1 = 0; mon_done_lat = -1; mon_done_n = 0;
        mon_err_lat = -1; mon_err_n = 0;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic run_xfer(input bit o, input int ri, input int rj, input int d, input bit ai);
        build_trace(o, ri, rj, d, ai);
        clear_mon();
        exp_o = '0;
        start = 1'b1; op = o; Ri = SW'(ri); Rj = SW'(rj); MFC = 1'($urandom);
`ifdef XFER_AUTOINC_EN
        autoinc = ai;
`endif
        start_cyc = cyc;
        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk); #1;
            exp_o = trace[i];
            start = 1'($urandom); op = 1'($urandom);
            Ri = SW'($urandom); Rj = SW'($urandom);
`ifdef XFER_AUTOINC_EN
            autoinc = 1'($urandom);
`endif
            MFC = (widx[i] >= 0) ? (widx[i] == d) : 1'($urandom);
        end
        @(posedge clk); #1;
        exp_o = '0; start = 1'b0; MFC = 1'($urandom);
    endtask

    task automatic reset_mid();
        build_trace(1'b0, 0, 1, NEVER, 1'b0);
        clear_mon();
        exp_o = '0; start = 1'b1; op = 1'b0; Ri = SW'(0); Rj = SW'(1); MFC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_o = trace[i]; start = 1'b0; MFC = 1'b0;
        end
        #2 reset = 1'b0; exp_o = '0;
        #1 check("async_reset_outputs", int'(dut_outs()), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit o, ai;
        int ri, rj, d;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_xfer(1'b0, 4, 2, 0, 1'b0);
        check("load_done_latency", mon_done_lat, 6);
        check("load_addr_reg_read", mon_addr_rr, 'b10000);
        check("load_wb_reg_write", mon_wb, 'b00100);

        run_xfer(1'b1, 1, 3, 4, 1'b0);
        check("store_done_latency", mon_done_lat, 9);
        check("store_data_reg_read", mon_data_rr, 'b01000);
        check("store_memrw_high_cycles", mon_rw1, 0);
        check("store_no_reg_write", mon_wb, 0);
        check("store_mem_en_cycles", mon_memen, 6);

        run_xfer(1'b0, 0, 1, NEVER, 1'b0);
        check("timeout_mem_en_cycles", mon_memen, 1 + 15);
        check("timeout_err_latency", mon_err_lat, 18);
        check("timeout_err_pulses", mon_err_n, 1);
        check("timeout_no_done", mon_done_n, 0);

        run_xfer(1'b0, 7, 1, 0, 1'b0);
        check("badidx_err_latency", mon_err_lat, 1);
        check("badidx_no_mem_en", mon_memen, 0);
        check("badidx_no_mar_write", mon_marw, 0);

        run_xfer(1'b1, 2, 2, 0, 1'b0);
        check("store_min_latency", mon_done_lat, 5);

        run_xfer(1'b0, 1, 3, 14, 1'b0);
        check("mfc_on_last_wait_done", mon_done_n, 1);

        reset_mid();
        run_xfer(1'b0, 3, 0, 2, 1'b0);
        check("post_reset_load_latency", mon_done_lat, 8);

`ifdef XFER_AUTOINC_EN
        run_xfer(1'b1, 0, 2, 0, 1'b1);
        check("autoinc_on_reg_inc", mon_inc, 'b00001);
        run_xfer(1'b1, 0, 2, 0, 1'b0);
        check("autoinc_off_reg_inc", mon_inc, 0);
`endif

        for (int t = 0; t < 120; t++) begin
            o  = 1'($urandom);
            ri = int'($urandom_range(0, 6));
            rj = int'($urandom_range(0, 6));
            d  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 17));
`ifdef XFER_AUTOINC_EN
            ai = 1'($urandom);
`else
            ai = 1'b0;
`endif
            run_xfer(o, ri, rj, d, ai);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_xfer_fsm.md
Name: mem_xfer_fsm

Overview:
Parametrised memory-transfer controller for the CPU datapath. It executes a LOAD (Rj <- M[Ri]) or a STORE (M[Ri] <- Rj) over the shared bus using MAR/MDR and the MFC completion handshake. It supports NUM_REGS registers through one-hot strobe vectors, and an MFC wait timeout with error reporting. The block sits beside the other instruction FSMs and is launched by the control unit with a one-cycle start.

Parameters:
NUM_REGS, 5, number of bus-attached registers (R0..R3, P0 = index 4 by default); range 2..32
SEL_W, 6, width of the Ri/Rj selector inputs
WAIT_MAX, 15, maximum cycles spent in WAIT before timeout; 0 disables the timeout
CNT_W, 8, width of the wait counter; must satisfy WAIT_MAX < 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  launch request; sampled only in IDLE
op  in  1  0 = LOAD, 1 = STORE; latched on start
Ri  in  SEL_W  address-register index; latched on start
Rj  in  SEL_W  data-register index (LOAD destination, STORE source); latched on start
MFC  in  1  memory function complete, active-high; sampled only in WAIT
reg_read  out  NUM_REGS  one-hot register bus-drive strobe
reg_write  out  NUM_REGS  one-hot register bus-capture strobe
MAR_write  out  1  MAR captures from bus
MAR_mem_read  out  1  MAR drives memory address
MEM_EN  out  1  memory enable
MEM_RW  out  1  1 = read, 0 = write
MDR_mem_write  out  1  MDR captures from memory
MDR_read  out  1  MDR drives bus
MDR_write  out  1  MDR captures from bus
MDR_mem_read  out  1  MDR drives memory data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on timeout or bad index

Behaviour:
- Reset (reset = 0, asynchronous): state goes to IDLE; every output is 0; latched op/Ri/Rj and the wait counter clear. Reset mid-transfer aborts immediately with no done or err pulse.
- Outputs are Moore: decoded only from the present state and the latched operands. Every output not listed for a state is 0.
- IDLE: if start = 1, latch op/Ri/Rj. If latched Ri >= NUM_REGS or Rj >= NUM_REGS, go to ERR; otherwise go to ADDR. start is ignored in all other states.
- ADDR: reg_read[Ri] = 1, MAR_write = 1. Next state is DATA for a STORE, REQ for a LOAD.
- DATA (STORE only): reg_read[Rj] = 1, MDR_write = 1. Next state is REQ.
- REQ: MEM_EN = 1, MAR_mem_read = 1.
  - LOAD: MEM_RW = 1.
  - STORE: MEM_RW = 0, MDR_mem_read = 1.
  - Clear the wait counter. Next state is WAIT.
- WAIT: same memory strobes as REQ, held.
  - MFC = 1: LOAD goes to CAPT, STORE goes to DONE.
  - Otherwise the counter increments. If WAIT_MAX != 0 and counter == WAIT_MAX-1 with MFC = 0, go to ERR. MFC wins if it arrives on that same cycle.
- CAPT (LOAD only): MDR_mem_write = 1. Next state is WB.
- WB: MDR_read = 1, reg_write[Rj] = 1. Next state is DONE.
- DONE: done = 1. Next state is IDLE.
- ERR: err = 1, all bus strobes 0. Next state is IDLE.
- Latency from the start cycle to the done pulse, with MFC high on the first WAIT cycle:
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - Each extra WAIT cycle adds 1.
- Ri == Rj is legal. Back-to-back operation: start held high through DONE relaunches on the IDLE cycle after DONE.
- A glitch on MFC outside WAIT has no effect.

Optional Feature:
Macro XFER_AUTOINC_EN.
- Defined:
  - Adds input autoinc (1 bit, latched on start) and output reg_inc (NUM_REGS bits).
  - In DONE with latched autoinc = 1, reg_inc[Ri] = 1 for that one cycle, so the register file post-increments the address register.
  - reg_inc is 0 in all other states, on err, and at reset.
- Undefined: neither port exists and no increment occurs.

Test Plan:
- LOAD, Ri = 4, Rj = 2, MFC high on the first WAIT cycle -> ADDR/REQ/WAIT/CAPT/WB/DONE in sequence; reg_read = 5'b10000 in ADDR; reg_write = 5'b00100 in WB; done pulses 6 cycles after start.
- STORE, Ri = 1, Rj = 3, MFC delayed 4 cycles -> DATA asserts reg_read = 5'b01000 with MDR_write; MEM_RW = 0 throughout REQ/WAIT; done 9 cycles after start; no reg_write.
- LOAD with MFC never asserted, WAIT_MAX = 15 -> exactly 15 WAIT cycles, then err = 1 for one cycle, done stays 0, then IDLE.
- start with Ri = 7 (NUM_REGS = 5) -> ERR on the next cycle; no MEM_EN or MAR_write ever asserted.
- reset driven low in the second WAIT cycle of a LOAD -> all outputs 0 asynchronously; after release, busy = 0 and a new LOAD completes normally.
- With XFER_AUTOINC_EN defined, STORE Ri = 0, autoinc = 1 -> reg_inc = 5'b00001 only in the DONE cycle. Repeat with autoinc = 0 -> reg_inc stays 0.
